// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the SPI command receiver.
`default_nettype none
`timescale 1ns/1ps

package spi_rx_pkg;

  localparam int SPI_DATA_W_DEF = 16;
  localparam int SPI_SYNC_DEF   = 2;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2,
    DRAIN     = 2'd3
  } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_cmd_rx_if.sv
// Frame hand-off channel: the receiver is master, the trigger-pulse generator is slave.
`default_nettype none
`timescale 1ns/1ps

interface spi_cmd_rx_if
  import spi_rx_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
) ();

  logic [DATA_W-1:0] o_frame_data;
  logic              o_frame_valid;
  logic              i_frame_ready;

  modport master (
    output o_frame_data,
    output o_frame_valid,
    input  i_frame_ready
  );

  modport slave (
    input  o_frame_data,
    input  o_frame_valid,
    output i_frame_ready
  );

endinterface

`default_nettype wire

// File: rtl/spi_sync.sv
// Single-bit multi-stage synchronizer with a configurable reset level.
`default_nettype none
`timescale 1ns/1ps

module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  wire logic clk_i,
  input  wire logic rst_ni,
  input  wire logic d_i,
  output logic      q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_cmd_rx.sv
// Mode-0 write-only SPI slave: oversamples the pins, assembles MSB-first frames
// and hands them downstream through a one-entry holding register.
`default_nettype none
`timescale 1ns/1ps

module spi_cmd_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEF,
  parameter int SYNC_STAGES = SPI_SYNC_DEF
) (
  input  wire logic     CLK50M,
  input  wire logic     RESET_N,
  input  wire logic     SPI_CS,
  input  wire logic     SPI_CLK,
  input  wire logic     SPI_MOSI,
  spi_cmd_rx_if.master  frame_if,
  output logic          o_frame_err,
  output logic          o_ovf,
  input  wire logic     i_ovf_clr,
  output logic          o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic w_cs_s, w_clk_s, w_mosi_s;
  logic cs_d1_q, clk_d1_q;
  logic w_sclk_rise, w_cs_fall, w_cs_rise, w_primed, w_accept;

  logic [SYNC_STAGES-1:0] prime_q;
  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic                   extra_q, extra_d;
  logic                   ld_q, ld_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      data_q;
  logic                   valid_q;
  logic                   ovf_q;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i (CLK50M), .rst_ni(RESET_N), .d_i(SPI_CS),   .q_o(w_cs_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk_i (CLK50M), .rst_ni(RESET_N), .d_i(SPI_CLK),  .q_o(w_clk_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (CLK50M), .rst_ni(RESET_N), .d_i(SPI_MOSI), .q_o(w_mosi_s)
  );

  assign w_sclk_rise = w_clk_s & ~clk_d1_q;
  assign w_cs_fall   = ~w_cs_s & cs_d1_q;
  assign w_cs_rise   = w_cs_s & ~cs_d1_q;
  // Synchronizer outputs carry reset levels, not pin levels, until the chain has refilled.
  assign w_primed    = prime_q[SYNC_STAGES-1];
  assign w_accept    = valid_q & frame_if.i_frame_ready;

  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_d1_q  <= 1'b1;
      clk_d1_q <= 1'b0;
      prime_q  <= '0;
      state_q  <= WAIT_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      extra_q  <= 1'b0;
      ld_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cs_d1_q  <= w_cs_s;
      clk_d1_q <= w_clk_s;
      prime_q  <= {prime_q[SYNC_STAGES-2:0], 1'b1};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      extra_q  <= extra_d;
      ld_q     <= ld_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    extra_d = extra_q;
    ld_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (w_primed && w_cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (w_cs_fall) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        // A completed frame wins even if CS is already rising in the same cycle.
        if (cnt_q == CNT_W'(DATA_W)) begin
          ld_d    = 1'b1;
          extra_d = 1'b0;
          state_d = w_cs_rise ? IDLE : DRAIN;
        end else if (w_cs_rise) begin
          err_d   = (cnt_q != '0);
          state_d = IDLE;
        end else if (w_sclk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], w_mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (w_cs_rise) begin
          err_d   = extra_q | w_sclk_rise;
          state_d = IDLE;
        end else if (w_sclk_rise) begin
          extra_d = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (ld_q && (!valid_q || w_accept)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (w_accept) begin
        valid_q <= 1'b0;
      end

      if (ld_q && valid_q && !w_accept) begin
        ovf_q <= 1'b1;
      end else if (i_ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign frame_if.o_frame_data  = data_q;
  assign frame_if.o_frame_valid = valid_q;
  assign o_frame_err            = err_q;
  assign o_ovf                  = ovf_q;
  assign o_busy                 = (state_q == RECV) || (state_q == DRAIN);

endmodule

`default_nettype wire
